// File: rtl/ascon_bdi_packer.sv
// Byte-serial to CCW-bit packer for the Ascon core bdi port.
// Holds one filling or closed accumulator and one output word register.
module ascon_bdi_packer #(
    parameter int CCW   = 32,
    parameter int CCWD8 = CCW / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_type,
    input  logic             in_eot,
    input  logic             in_eoi,
    output logic [CCW-1:0]   bdi,
    output logic [CCWD8-1:0] bdi_valid,
    input  logic             bdi_ready,
    output logic [3:0]       bdi_type,
    output logic             bdi_eot,
    output logic             bdi_eoi,
    output logic             err
);

    localparam int CW = $clog2(CCWD8 + 1);

    typedef enum logic {FILL, CLOSED} acc_state_e;

    acc_state_e       state_q, state_d;
    logic [CCW-1:0]   acc_data_q, acc_data_d;
    logic [CW-1:0]    acc_cnt_q, acc_cnt_d;
    logic [3:0]       acc_type_q, acc_type_d;
    logic             acc_eot_q, acc_eot_d;
    logic             acc_eoi_q, acc_eoi_d;
    logic [CCW-1:0]   out_data_q, out_data_d;
    logic [CCWD8-1:0] out_mask_q, out_mask_d;
    logic [3:0]       out_type_q, out_type_d;
    logic             out_eot_q, out_eot_d;
    logic             out_eoi_q, out_eoi_d;
    logic             err_q, err_d;
    logic             run_q, run_d;

    logic out_busy, move, type_clash, ready_c, accept;

    always_comb begin
        out_busy   = |out_mask_q;
        move       = (state_q == CLOSED) && (!out_busy || bdi_ready);
        type_clash = run_q && in_valid && (state_q == FILL) &&
                     (acc_cnt_q != '0) && (in_type != acc_type_q);
        ready_c    = run_q && ((state_q == FILL) || move) && !type_clash;
        accept     = in_valid && ready_c;

        state_d    = state_q;
        acc_data_d = acc_data_q;
        acc_cnt_d  = acc_cnt_q;
        acc_type_d = acc_type_q;
        acc_eot_d  = acc_eot_q;
        acc_eoi_d  = acc_eoi_q;
        out_data_d = out_data_q;
        out_mask_d = out_mask_q;
        out_type_d = out_type_q;
        out_eot_d  = out_eot_q;
        out_eoi_d  = out_eoi_q;
        err_d      = err_q;
        run_d      = 1'b1;

        if (move) begin
            out_data_d = acc_data_q;
            out_type_d = acc_type_q;
            out_eot_d  = acc_eot_q;
            out_eoi_d  = acc_eoi_q;
            for (int unsigned k = 0; k < CCWD8; k++)
                out_mask_d[k] = (CW'(k) < acc_cnt_q);
            state_d    = FILL;
            acc_data_d = '0;
            acc_cnt_d  = '0;
            acc_type_d = '0;
            acc_eot_d  = 1'b0;
            acc_eoi_d  = 1'b0;
        end else if (out_busy && bdi_ready) begin
            out_data_d = '0;
            out_mask_d = '0;
            out_type_d = '0;
            out_eot_d  = 1'b0;
            out_eoi_d  = 1'b0;
        end

        // Lane selection uses the post-move count, so a byte taken during a move lands in lane 0.
        if (accept) begin
            for (int unsigned k = 0; k < CCWD8; k++)
                if (CW'(k) == acc_cnt_d)
                    acc_data_d[8*k +: 8] = in_data;
            acc_cnt_d  = acc_cnt_d + CW'(1);
            acc_type_d = in_type;
            acc_eot_d  = in_eot || in_eoi;
            acc_eoi_d  = in_eoi;
            if ((acc_cnt_d == CW'(CCWD8)) || in_eot || in_eoi)
                state_d = CLOSED;
        end

        if (type_clash) begin
            state_d = CLOSED;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            acc_data_q <= '0;
            acc_cnt_q  <= '0;
            acc_type_q <= '0;
            acc_eot_q  <= 1'b0;
            acc_eoi_q  <= 1'b0;
            out_data_q <= '0;
            out_mask_q <= '0;
            out_type_q <= '0;
            out_eot_q  <= 1'b0;
            out_eoi_q  <= 1'b0;
            err_q      <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_data_q <= acc_data_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_type_q <= acc_type_d;
            acc_eot_q  <= acc_eot_d;
            acc_eoi_q  <= acc_eoi_d;
            out_data_q <= out_data_d;
            out_mask_q <= out_mask_d;
            out_type_q <= out_type_d;
            out_eot_q  <= out_eot_d;
            out_eoi_q  <= out_eoi_d;
            err_q      <= err_d;
            run_q      <= run_d;
        end
    end

    assign in_ready  = ready_c;
    assign bdi       = out_data_q;
    assign bdi_valid = out_mask_q;
    assign bdi_type  = out_type_q;
    assign bdi_eot   = out_eot_q;
    assign bdi_eoi   = out_eoi_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ascon_bdi_packer.sv
// Directed bench for ascon_bdi_packer at CCW=32.
module tb_ascon_bdi_packer;

    localparam logic [3:0] D_NONCE = 4'd1;
    localparam logic [3:0] D_AD    = 4'd2;
    localparam logic [3:0] D_MSG   = 4'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_type = '0;
    logic        in_eot = 1'b0;
    logic        in_eoi = 1'b0;
    logic [31:0] bdi;
    logic [3:0]  bdi_valid;
    logic        bdi_ready = 1'b0;
    logic [3:0]  bdi_type;
    logic        bdi_eot;
    logic        bdi_eoi;
    logic        err;

    int checks = 0;
    int errors = 0;

    ascon_bdi_packer #(.CCW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_eot(in_eot), .in_eoi(in_eoi),
        .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready),
        .bdi_type(bdi_type), .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi),
        .err(err)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic v, input logic [7:0] d, input logic [3:0] t,
                         input logic eot, input logic eoi);
        @(negedge clk);
        in_valid = v; in_data = d; in_type = t; in_eot = eot; in_eoi = eoi;
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi, err, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got bdi=%h mask=%b type=%h eot=%b eoi=%b err=%b in_ready=%b, want all 0",
                     bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi, err, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bdi_ready = 1'b1;
    endtask

    task automatic test_nonce_stream;
        logic [31:0] words [4];
        words[0] = 32'h03020100; words[1] = 32'h07060504;
        words[2] = 32'h0B0A0908; words[3] = 32'h0F0E0D0C;
        for (int n = 0; n < 18; n++) begin
            if (n < 16) drive(1'b1, 8'(n), D_NONCE, n == 15, 1'b0);
            else        drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
            if (n < 16) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL nonce_in_ready[%0d]: got %b want 1", n, in_ready);
                end
            end
            if (n >= 5 && (n - 5) % 4 == 0) begin
                checks++;
                if (bdi_valid !== 4'hF || bdi !== words[(n-5)/4] || bdi_type !== D_NONCE ||
                    bdi_eot !== (n == 17) || bdi_eoi !== 1'b0) begin
                    errors++;
                    $display("FAIL nonce_word[%0d]: got bdi=%h mask=%b type=%h eot=%b eoi=%b want bdi=%h mask=1111 type=%h eot=%b eoi=0",
                             (n-5)/4, bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi,
                             words[(n-5)/4], D_NONCE, n == 17);
                end
            end else if (n >= 1) begin
                checks++;
                if (bdi_valid !== 4'h0) begin
                    errors++;
                    $display("FAIL nonce_gap[%0d]: got mask=%b want 0000", n, bdi_valid);
                end
            end
        end
    endtask

    task automatic test_ad_partial;
        drive(1'b1, 8'hA1, D_AD, 1'b0, 1'b0);
        drive(1'b1, 8'hA2, D_AD, 1'b0, 1'b0);
        drive(1'b1, 8'hA3, D_AD, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (bdi_valid !== 4'h0) begin
            errors++;
            $display("FAIL ad_early: got mask=%b want 0000", bdi_valid);
        end
        drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (bdi !== 32'h00A3A2A1 || bdi_valid !== 4'b0111 || bdi_type !== D_AD ||
            bdi_eot !== 1'b1 || bdi_eoi !== 1'b0) begin
            errors++;
            $display("FAIL ad_word: got bdi=%h mask=%b type=%h eot=%b eoi=%b want bdi=00a3a2a1 mask=0111 type=%h eot=1 eoi=0",
                     bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi, D_AD);
        end
        drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_eoi_single;
        drive(1'b1, 8'h55, D_MSG, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (bdi !== 32'h00000055 || bdi_valid !== 4'b0001 || bdi_type !== D_MSG ||
            bdi_eot !== 1'b1 || bdi_eoi !== 1'b1) begin
            errors++;
            $display("FAIL eoi_word: got bdi=%h mask=%b type=%h eot=%b eoi=%b want bdi=00000055 mask=0001 type=%h eot=1 eoi=1",
                     bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi, D_MSG);
        end
        drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure;
        int idx = 0;
        bdi_ready = 1'b0;
        for (int n = 0; n < 12; n++) begin
            drive(1'b1, 8'h20 + 8'(idx), D_MSG, 1'b0, 1'b0);
            if (in_ready) idx++;
            if (n >= 5) begin
                checks++;
                if (bdi !== 32'h23222120 || bdi_valid !== 4'hF || bdi_type !== D_MSG || bdi_eot !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_stable[%0d]: got bdi=%h mask=%b type=%h eot=%b want bdi=23222120 mask=1111 type=%h eot=0",
                             n, bdi, bdi_valid, bdi_type, bdi_eot, D_MSG);
                end
            end
        end
        checks++;
        if (idx !== 8 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accepted: got %0d bytes in_ready=%b want 8 bytes in_ready=0", idx, in_ready);
        end
        drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        bdi_ready = 1'b1;
        #1;
        checks++;
        if (bdi !== 32'h23222120 || bdi_valid !== 4'hF) begin
            errors++;
            $display("FAIL bp_drain0: got bdi=%h mask=%b want bdi=23222120 mask=1111", bdi, bdi_valid);
        end
        drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (bdi !== 32'h27262524 || bdi_valid !== 4'hF) begin
            errors++;
            $display("FAIL bp_drain1: got bdi=%h mask=%b want bdi=27262524 mask=1111", bdi, bdi_valid);
        end
        drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (bdi_valid !== 4'h0) begin
            errors++;
            $display("FAIL bp_empty: got mask=%b want 0000", bdi_valid);
        end
    endtask

    task automatic test_type_clash;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL clash_err_before: got %b want 0", err);
        end
        drive(1'b1, 8'h11, D_AD, 1'b0, 1'b0);
        drive(1'b1, 8'h12, D_AD, 1'b0, 1'b0);
        drive(1'b1, 8'h33, D_MSG, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clash_stall: got in_ready=%b want 0", in_ready);
        end
        drive(1'b1, 8'h33, D_MSG, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL clash_retake: got in_ready=%b err=%b want in_ready=1 err=1", in_ready, err);
        end
        drive(1'b1, 8'h34, D_MSG, 1'b1, 1'b0);
        checks++;
        if (bdi !== 32'h00001211 || bdi_valid !== 4'b0011 || bdi_type !== D_AD || bdi_eot !== 1'b0) begin
            errors++;
            $display("FAIL clash_ad_word: got bdi=%h mask=%b type=%h eot=%b want bdi=00001211 mask=0011 type=%h eot=0",
                     bdi, bdi_valid, bdi_type, bdi_eot, D_AD);
        end
        drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (bdi !== 32'h00003433 || bdi_valid !== 4'b0011 || bdi_type !== D_MSG ||
            bdi_eot !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL clash_msg_word: got bdi=%h mask=%b type=%h eot=%b err=%b want bdi=00003433 mask=0011 type=%h eot=1 err=1",
                     bdi, bdi_valid, bdi_type, bdi_eot, err, D_MSG);
        end
        drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_word;
        bdi_ready = 1'b0;
        for (int n = 0; n < 6; n++)
            drive(1'b1, 8'h40 + 8'(n), D_AD, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (bdi_valid !== 4'hF || bdi !== 32'h43424140) begin
            errors++;
            $display("FAIL rst_pending: got bdi=%h mask=%b want bdi=43424140 mask=1111", bdi, bdi_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bdi_valid !== 4'h0 || in_ready !== 1'b0 || bdi !== 32'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got mask=%b in_ready=%b bdi=%h err=%b want all 0",
                     bdi_valid, in_ready, bdi, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bdi_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_release_ready: got %b want 0 before first edge", in_ready);
        end
        drive(1'b1, 8'h50, D_AD, 1'b0, 1'b0);
        drive(1'b1, 8'h51, D_AD, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        checks++;
        if (bdi !== 32'h00005150 || bdi_valid !== 4'b0011 || bdi_type !== D_AD || bdi_eot !== 1'b1) begin
            errors++;
            $display("FAIL rst_first_word: got bdi=%h mask=%b type=%h eot=%b want bdi=00005150 mask=0011 type=%h eot=1",
                     bdi, bdi_valid, bdi_type, bdi_eot, D_AD);
        end
    endtask

    initial begin
        test_reset;
        test_nonce_stream;
        test_ad_partial;
        test_eoi_single;
        test_backpressure;
        test_type_clash;
        test_reset_mid_word;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
